// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: buffered bridge between the cache memory-side port and
// main memory. Requests queue in a small FIFO, issue to memory only while a
// response slot is guaranteed (credits), and responses return in order through
// a second FIFO. All handshake outputs decode registered state only.

module cache_mem_bridge_checker #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          mem_req_fire,
    input logic          mem_resp_fire,
    input logic [CW-1:0] outstanding
);
    // A memory response with nothing in flight (and no issue on the same edge) breaks the protocol
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset)
        mem_resp_fire |-> ((outstanding != {CW{1'b0}}) || mem_req_fire));
endmodule

module cache_mem_bridge #(
    parameter int REQ_DEPTH  = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cache_req_val,
    output logic                              cache_req_rdy,
    input  logic [76:0]                       cache_req_msg,
    output logic                              cache_resp_val,
    input  logic                              cache_resp_rdy,
    output logic [46:0]                       cache_resp_msg,
    output logic                              mem_req_val,
    input  logic                              mem_req_rdy,
    output logic [76:0]                       mem_req_msg,
    input  logic                              mem_resp_val,
    output logic                              mem_resp_rdy,
    input  logic [46:0]                       mem_resp_msg,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   outstanding,
    output logic                              idle
);
    localparam int CW  = $clog2(RESP_DEPTH + 1);
    localparam int SW  = CW + 1;
    localparam int QW  = $clog2(REQ_DEPTH + 1);
    localparam int QPW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int RPW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [QW-1:0]  REQ_FULL   = QW'(REQ_DEPTH);
    localparam logic [CW-1:0]  RESP_FULL  = CW'(RESP_DEPTH);
    localparam logic [SW-1:0]  CREDIT_MAX = SW'(RESP_DEPTH);
    localparam logic [QPW-1:0] REQ_LAST   = QPW'(REQ_DEPTH - 1);
    localparam logic [RPW-1:0] RESP_LAST  = RPW'(RESP_DEPTH - 1);

    logic [76:0]    req_mem_r [REQ_DEPTH];
    logic [QPW-1:0] req_wr_r;
    logic [QPW-1:0] req_rd_r;
    logic [QW-1:0]  req_count_r;
    logic [46:0]    resp_mem_r [RESP_DEPTH];
    logic [RPW-1:0] resp_wr_r;
    logic [RPW-1:0] resp_rd_r;
    logic [CW-1:0]  resp_count_r;
    logic [CW-1:0]  outstanding_r;
    logic           run_r;

    logic           req_enq_s;
    logic           req_deq_s;
    logic           resp_enq_s;
    logic           resp_deq_s;
    logic [SW-1:0]  credit_sum_s;

    function automatic logic [QPW-1:0] req_ptr_inc(input logic [QPW-1:0] p);
        if (p == REQ_LAST) begin
            req_ptr_inc = {QPW{1'b0}};
        end else begin
            req_ptr_inc = p + QPW'(1'b1);
        end
    endfunction

    function automatic logic [RPW-1:0] resp_ptr_inc(input logic [RPW-1:0] p);
        if (p == RESP_LAST) begin
            resp_ptr_inc = {RPW{1'b0}};
        end else begin
            resp_ptr_inc = p + RPW'(1'b1);
        end
    endfunction

    // Credits: in-flight requests plus buffered responses may never exceed response storage
    assign credit_sum_s   = {1'b0, outstanding_r} + {1'b0, resp_count_r};

    assign cache_req_rdy  = run_r & (req_count_r != REQ_FULL);
    assign mem_req_val    = (req_count_r != {QW{1'b0}}) & (credit_sum_s < CREDIT_MAX);
    assign mem_req_msg    = req_mem_r[req_rd_r];
    assign mem_resp_rdy   = run_r & (resp_count_r != RESP_FULL);
    assign cache_resp_val = (resp_count_r != {CW{1'b0}});
    assign cache_resp_msg = resp_mem_r[resp_rd_r];
    assign outstanding    = outstanding_r;
    assign idle           = (req_count_r == {QW{1'b0}}) & (outstanding_r == {CW{1'b0}})
                          & (resp_count_r == {CW{1'b0}});

    assign req_enq_s  = cache_req_val & cache_req_rdy;
    assign req_deq_s  = mem_req_val & mem_req_rdy;
    assign resp_enq_s = mem_resp_val & mem_resp_rdy;
    assign resp_deq_s = cache_resp_val & cache_resp_rdy;

    // Hold the cache-facing ready low until the first clock after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Request FIFO: enqueue from the cache, dequeue when memory takes the head entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REQ_DEPTH; i++) begin
                req_mem_r[i] <= {77{1'b0}};
            end
            req_wr_r    <= {QPW{1'b0}};
            req_rd_r    <= {QPW{1'b0}};
            req_count_r <= {QW{1'b0}};
        end else begin
            if (req_enq_s) begin
                req_mem_r[req_wr_r] <= cache_req_msg;
                req_wr_r            <= req_ptr_inc(req_wr_r);
            end
            if (req_deq_s) begin
                req_rd_r <= req_ptr_inc(req_rd_r);
            end
            case ({req_enq_s, req_deq_s})
                2'b10:   req_count_r <= req_count_r + QW'(1'b1);
                2'b01:   req_count_r <= req_count_r - QW'(1'b1);
                default: req_count_r <= req_count_r;
            endcase
        end
    end

    // Response FIFO and in-flight counter; issue and response on one edge cancel out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                resp_mem_r[i] <= {47{1'b0}};
            end
            resp_wr_r     <= {RPW{1'b0}};
            resp_rd_r     <= {RPW{1'b0}};
            resp_count_r  <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
        end else begin
            if (resp_enq_s) begin
                resp_mem_r[resp_wr_r] <= mem_resp_msg;
                resp_wr_r             <= resp_ptr_inc(resp_wr_r);
            end
            if (resp_deq_s) begin
                resp_rd_r <= resp_ptr_inc(resp_rd_r);
            end
            case ({resp_enq_s, resp_deq_s})
                2'b10:   resp_count_r <= resp_count_r + CW'(1'b1);
                2'b01:   resp_count_r <= resp_count_r - CW'(1'b1);
                default: resp_count_r <= resp_count_r;
            endcase
            case ({req_deq_s, resp_enq_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    cache_mem_bridge_checker #(.CW(CW)) u_checker (
        .clk           (clk),
        .reset         (reset),
        .mem_req_fire  (req_deq_s),
        .mem_resp_fire (resp_enq_s),
        .outstanding   (outstanding_r)
    );

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: the bench plays both the cache and a
// memory that answers in request order, optionally in the same cycle as issue.

module tb_cache_mem_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        cache_req_val;
    logic        cache_req_rdy;
    logic [76:0] cache_req_msg;
    logic        cache_resp_val;
    logic        cache_resp_rdy;
    logic [46:0] cache_resp_msg;
    logic        mem_req_val;
    logic        mem_req_rdy;
    logic [76:0] mem_req_msg;
    logic        mem_resp_val;
    logic        mem_resp_rdy;
    logic [46:0] mem_resp_msg;
    logic [2:0]  outstanding;
    logic        idle;

    int          checks = 0;
    int          errors = 0;
    int          mem_fires = 0;
    logic        resp_en = 1'b0;
    logic [76:0] pend_q[$];
    logic [46:0] got_q[$];

    cache_mem_bridge #(.REQ_DEPTH(2), .RESP_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cache_req_val(cache_req_val), .cache_req_rdy(cache_req_rdy), .cache_req_msg(cache_req_msg),
        .cache_resp_val(cache_resp_val), .cache_resp_rdy(cache_resp_rdy), .cache_resp_msg(cache_resp_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .outstanding(outstanding), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [76:0] mk_req(input logic [7:0] opq, input logic [31:0] addr);
        mk_req = {3'd0, opq, addr, 2'd0, 32'd0};
    endfunction

    // Memory reply: data = 0xdeadbeef XOR (addr - 0x1000), header fields echoed
    function automatic logic [46:0] mem_reply(input logic [76:0] req);
        mem_reply = {req[76:74], req[73:66], 2'b00, req[33:32], 32'hdeadbeef ^ (req[65:34] - 32'h00001000)};
    endfunction

    // Memory drive: oldest pending reply first, else answer the current request combinationally
    always @(negedge clk) begin
        #1;
        if (!reset || !resp_en) begin
            mem_resp_val = 1'b0;
            mem_resp_msg = 47'd0;
        end else if (pend_q.size() > 0) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = mem_reply(pend_q[0]);
        end else if (mem_req_val && mem_req_rdy) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = mem_reply(mem_req_msg);
        end else begin
            mem_resp_val = 1'b0;
            mem_resp_msg = 47'd0;
        end
    end

    // Memory bookkeeping and cache-side response capture
    always @(posedge clk) begin
        if (!reset) begin
            pend_q.delete();
        end else begin
            if (mem_req_val && mem_req_rdy) begin
                pend_q.push_back(mem_req_msg);
                mem_fires++;
            end
            if (mem_resp_val && mem_resp_rdy) begin
                void'(pend_q.pop_front());
            end
            if (cache_resp_val && cache_resp_rdy) begin
                got_q.push_back(cache_resp_msg);
            end
        end
    end

    task automatic send(input logic [76:0] msg);
        int n;
        n = 0;
        cache_req_val = 1'b1;
        cache_req_msg = msg;
        while (!cache_req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cache_req_val = 1'b0;
        checks++;
        if (n >= 50) begin errors++; $display("FAIL send_accept opaque %0h not accepted in 50 cycles", msg[73:66]); end
    endtask

    task automatic wait_got(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (got_q.size() < n) begin errors++; $display("FAIL wait_resp got %0d responses need %0d", got_q.size(), n); end
    endtask

    task automatic test_reset();
        cache_req_val = 1'b1; cache_req_msg = mk_req(8'hff, 32'hffff0000);
        cache_resp_rdy = 1'b1; mem_req_rdy = 1'b1; resp_en = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (cache_req_rdy !== 1'b0) begin errors++; $display("FAIL rst_req_rdy got %b exp 0", cache_req_rdy); end
        end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
        checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL rst_mem_req_val got %b exp 0", mem_req_val); end
        checks++; if (cache_resp_val !== 1'b0) begin errors++; $display("FAIL rst_resp_val got %b exp 0", cache_resp_val); end
        reset = 1'b1; cache_req_val = 1'b0;
        #1;
        checks++; if (cache_req_rdy !== 1'b0) begin errors++; $display("FAIL rel_rdy_same_cycle got %b exp 0", cache_req_rdy); end
        @(negedge clk);
        checks++; if (cache_req_rdy !== 1'b1) begin errors++; $display("FAIL rel_rdy got %b exp 1", cache_req_rdy); end
        checks++; if (mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL rel_mem_resp_rdy got %b exp 1", mem_resp_rdy); end
        checks++; if (mem_req_msg !== 77'd0) begin errors++; $display("FAIL rel_mem_req_msg got %h exp 0", mem_req_msg); end
        checks++; if (cache_resp_msg !== 47'd0) begin errors++; $display("FAIL rel_resp_msg got %h exp 0", cache_resp_msg); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rel_idle got %b exp 1", idle); end
    endtask

    task automatic test_single_read();
        logic [76:0] req;
        got_q.delete(); resp_en = 1'b1; cache_resp_rdy = 1'b1;
        req = mk_req(8'h05, 32'h00001000);
        cache_req_val = 1'b1; cache_req_msg = req;
        @(negedge clk);
        cache_req_val = 1'b0;
        checks++; if (mem_req_val !== 1'b1) begin errors++; $display("FAIL rd_mem_req_val got %b exp 1", mem_req_val); end
        checks++; if (mem_req_msg !== req) begin errors++; $display("FAIL rd_mem_req_msg got %h exp %h", mem_req_msg, req); end
        checks++; if (cache_resp_val !== 1'b0) begin errors++; $display("FAIL rd_resp_early got %b exp 0", cache_resp_val); end
        @(negedge clk);
        checks++; if (cache_resp_val !== 1'b1) begin errors++; $display("FAIL rd_resp_val got %b exp 1", cache_resp_val); end
        checks++; if (cache_resp_msg !== {3'd0, 8'h05, 2'b00, 2'b00, 32'hdeadbeef}) begin
            errors++; $display("FAIL rd_resp_msg got %h exp opaque 05 data deadbeef", cache_resp_msg); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rd_outstanding got %0d exp 0", outstanding); end
        @(negedge clk);
        checks++; if (idle !== 1'b1 || got_q.size() != 1) begin
            errors++; $display("FAIL rd_done idle %b responses %0d exp 1 and 1", idle, got_q.size()); end
    endtask

    task automatic test_credit_limit();
        int base;
        logic [31:0] a;
        logic [7:0] o;
        got_q.delete(); resp_en = 1'b0; cache_resp_rdy = 1'b1; base = mem_fires;
        for (int i = 0; i < 6; i++) send(mk_req(8'(8'h10 + i), 32'h00003000 + 32'(4 * i)));
        cache_req_val = 1'b1; cache_req_msg = mk_req(8'h16, 32'h00003018);
        repeat (4) @(negedge clk);
        checks++; if (mem_fires - base != 4) begin errors++; $display("FAIL cr_mem_fires got %0d exp 4", mem_fires - base); end
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL cr_outstanding got %0d exp 4", outstanding); end
        checks++; if (cache_req_rdy !== 1'b0) begin errors++; $display("FAIL cr_req_full_rdy got %b exp 0", cache_req_rdy); end
        checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL cr_mem_req_val got %b exp 0", mem_req_val); end
        resp_en = 1'b1;
        send(mk_req(8'h16, 32'h00003018));
        wait_got(7);
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            a = 32'h00003000 + 32'(4 * i);
            o = 8'(8'h10 + i);
            checks++; if (got_q[i][43:36] !== o || got_q[i][31:0] !== (32'hdeadbeef ^ (a - 32'h00001000))) begin
                errors++; $display("FAIL cr_order idx %0d got %h exp opaque %h", i, got_q[i], o); end
        end
        repeat (3) @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL cr_idle got %b exp 1", idle); end
    endtask

    task automatic test_backpressure();
        int base;
        logic [31:0] a;
        got_q.delete(); resp_en = 1'b1; cache_resp_rdy = 1'b0; base = mem_fires;
        for (int i = 0; i < 5; i++) send(mk_req(8'(8'h20 + i), 32'h00004000 + 32'(4 * i)));
        repeat (3) @(negedge clk);
        checks++; if (mem_fires - base != 4) begin errors++; $display("FAIL bp_mem_fires got %0d exp 4", mem_fires - base); end
        checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL bp_mem_req_val got %b exp 0", mem_req_val); end
        checks++; if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL bp_resp_full got %b exp 0", mem_resp_rdy); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL bp_outstanding got %0d exp 0", outstanding); end
        checks++; if (cache_resp_val !== 1'b1 || cache_resp_msg[43:36] !== 8'h20) begin
            errors++; $display("FAIL bp_head val %b opaque %h exp 1 and 20", cache_resp_val, cache_resp_msg[43:36]); end
        cache_resp_rdy = 1'b1;
        wait_got(5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            a = 32'h00004000 + 32'(4 * i);
            checks++; if (got_q[i][43:36] !== 8'(8'h20 + i) || got_q[i][31:0] !== (32'hdeadbeef ^ (a - 32'h00001000))) begin
                errors++; $display("FAIL bp_order idx %0d got %h", i, got_q[i]); end
        end
        checks++; if (mem_fires - base != 5) begin errors++; $display("FAIL bp_resume got %0d fires exp 5", mem_fires - base); end
    endtask

    task automatic test_simultaneous();
        got_q.delete(); resp_en = 1'b0; cache_resp_rdy = 1'b1;
        send(mk_req(8'h30, 32'h00005000));
        send(mk_req(8'h31, 32'h00005004));
        repeat (2) @(negedge clk);
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL sim_setup got %0d exp 2", outstanding); end
        cache_req_val = 1'b1; cache_req_msg = mk_req(8'h32, 32'h00005008);
        @(negedge clk);
        cache_req_val = 1'b0;
        checks++; if (mem_req_val !== 1'b1) begin errors++; $display("FAIL sim_req_ready got %b exp 1", mem_req_val); end
        resp_en = 1'b1;
        @(negedge clk);
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL sim_outstanding got %0d exp 2", outstanding); end
        checks++; if (cache_resp_val !== 1'b1 || cache_resp_msg[43:36] !== 8'h30) begin
            errors++; $display("FAIL sim_first_resp val %b opaque %h exp 1 and 30", cache_resp_val, cache_resp_msg[43:36]); end
        @(negedge clk);
        resp_en = 1'b0;
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL sim_out_dec got %0d exp 1", outstanding); end
        checks++; if (cache_resp_val !== 1'b1 || cache_resp_msg[43:36] !== 8'h31) begin
            errors++; $display("FAIL sim_enq_deq val %b opaque %h exp 1 and 31", cache_resp_val, cache_resp_msg[43:36]); end
        @(negedge clk);
        checks++; if (cache_resp_val !== 1'b0 || got_q.size() != 2) begin
            errors++; $display("FAIL sim_count val %b responses %0d exp 0 and 2", cache_resp_val, got_q.size()); end
        resp_en = 1'b1;
        wait_got(3);
        checks++; if (got_q.size() < 3 || got_q[2][43:36] !== 8'h32) begin
            errors++; $display("FAIL sim_last got %0d responses exp opaque 32 third", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        got_q.delete(); resp_en = 1'b0; cache_resp_rdy = 1'b1; mem_req_rdy = 1'b1;
        for (int i = 0; i < 3; i++) send(mk_req(8'(8'h40 + i), 32'h00006000 + 32'(4 * i)));
        repeat (2) @(negedge clk);
        mem_req_rdy = 1'b0;
        send(mk_req(8'h43, 32'h0000600c));
        send(mk_req(8'h44, 32'h00006010));
        checks++; if (outstanding !== 3'd3 || cache_req_rdy !== 1'b0) begin
            errors++; $display("FAIL mid_setup outstanding %0d rdy %b exp 3 and 0", outstanding, cache_req_rdy); end
        reset = 1'b0;
        #1;
        checks++; if (idle !== 1'b1 || outstanding !== 3'd0) begin
            errors++; $display("FAIL mid_clear idle %b outstanding %0d exp 1 and 0", idle, outstanding); end
        checks++; if (mem_req_val !== 1'b0 || cache_resp_val !== 1'b0) begin
            errors++; $display("FAIL mid_vals mem_req_val %b resp_val %b exp 0 and 0", mem_req_val, cache_resp_val); end
        repeat (2) @(negedge clk);
        reset = 1'b1; mem_req_rdy = 1'b1; resp_en = 1'b1;
        @(negedge clk);
        send(mk_req(8'h2a, 32'h00002000));
        wait_got(1);
        repeat (5) @(negedge clk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mid_stale got %0d responses exp 1", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== {3'd0, 8'h2a, 2'b00, 2'b00, 32'hdeadaeef}) begin
            errors++; $display("FAIL mid_read got %0d responses, exp opaque 2a data deadaeef", got_q.size()); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %b exp 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_credit_limit();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
